// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DEFAULT_CLK_PER_BIT = 868;
    localparam int DEFAULT_QADDR_W     = 9;

endpackage

// File: rtl/input_manager_receiver.sv
// UART frame deserialiser: 2-flop synchroniser plus bit-timing FSM.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module receiver
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic       CLK,
    input  logic       INITIALIZE,
    input  logic       UART_RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       err
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             stop_ok;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad_q, parity_bad_d;
`endif

    // Synchroniser idles high so a reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign stop_ok = !parity_bad_q;
`else
    assign stop_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid   = 1'b0;
        err     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        parity_bad_d = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    data_d[idx_q]  = rx_s_q;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    parity_bad_d = (^data_q) != rx_s_q;
                    state_d      = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    if (rx_s_q && stop_ok) begin
                        valid = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data = data_q;

endmodule

// File: rtl/input_manager.sv
// UART receive side: stores good bytes in a ring buffer owned by write pointer queue_t.
// Optional UART_RX_PARITY_EN macro enables even-parity checking in the receiver.
module input_manager
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int QADDR_W     = DEFAULT_QADDR_W
) (
    input  logic               CLK,
    input  logic               INITIALIZE,
    input  logic               UART_RX,
    input  logic [QADDR_W-1:0] queue_s,
    output logic [7:0]         recv_queue [0:(1<<QADDR_W)-1],
    output logic [QADDR_W-1:0] queue_t,
    output logic               overflow,
    output logic               frame_error
);

    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_err;
    logic [QADDR_W-1:0] queue_t_q, queue_t_d, queue_t_inc;
    logic               overflow_q, overflow_d;
    logic               frame_error_q, frame_error_d;
    logic               full;
    logic               wr_en;

    receiver #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_receiver (
        .CLK       (CLK),
        .INITIALIZE(INITIALIZE),
        .UART_RX   (UART_RX),
        .data      (rx_data),
        .valid     (rx_valid),
        .err       (rx_err)
    );

    // One slot is kept empty so full and empty stay distinguishable.
    always_comb begin
        queue_t_inc   = queue_t_q + QADDR_W'(1);
        full          = (queue_t_inc == queue_s);
        wr_en         = rx_valid && !full;
        queue_t_d     = wr_en ? queue_t_inc : queue_t_q;
        overflow_d    = overflow_q || (rx_valid && full);
        frame_error_d = frame_error_q || rx_err;
    end

    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            queue_t_q     <= '0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            queue_t_q     <= queue_t_d;
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!INITIALIZE && wr_en) begin
            recv_queue[queue_t_q] <= rx_data;
        end
    end

    assign queue_t     = queue_t_q;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_input_manager.sv
// Self-checking bench for input_manager: vector table, hand-written corner cases
// and random frames checked against a pointer/array model of the ring buffer.
module tb_input_manager;

    localparam int CPB   = 8;
    localparam int QW    = 9;
    localparam int DEPTH = 1 << QW;

    logic          CLK = 1'b0;
    logic          INITIALIZE;
    logic          UART_RX;
    logic [QW-1:0] queue_s;
    logic [7:0]    recv_queue [0:DEPTH-1];
    logic [QW-1:0] queue_t;
    logic          overflow;
    logic          frame_error;

    int checks   = 0;
    int failures = 0;

    int         m_t;
    int         m_s;
    bit         m_ovf;
    bit         m_fe;
    bit         m_wrote;
    int         m_last_addr;
    logic [7:0] m_mem [DEPTH];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         qs;
        int         exp_t;
        logic       exp_fe;
        logic       exp_ovf;
        int         addr;
    } vec_t;

    vec_t vecs [5];

    input_manager #(
        .CLK_PER_BIT(CPB),
        .QADDR_W    (QW)
    ) dut (
        .CLK        (CLK),
        .INITIALIZE (INITIALIZE),
        .UART_RX    (UART_RX),
        .queue_s    (queue_s),
        .recv_queue (recv_queue),
        .queue_t    (queue_t),
        .overflow   (overflow),
        .frame_error(frame_error)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        m_t   = 0;
        m_ovf = 1'b0;
        m_fe  = 1'b0;
    endfunction

    // Ring buffer semantics: one slot always left free, drops set overflow.
    function automatic void modelFrame(input logic [7:0] d, input logic stop_ok);
        m_wrote = 1'b0;
        if (!stop_ok) begin
            m_fe = 1'b1;
        end else if (((m_t + 1) % DEPTH) == m_s) begin
            m_ovf = 1'b1;
        end else begin
            m_mem[m_t]  = d;
            m_last_addr = m_t;
            m_wrote     = 1'b1;
            m_t         = (m_t + 1) % DEPTH;
        end
    endfunction

    task automatic setConsumer(input int s);
        queue_s = QW'(s);
        m_s     = s;
    endtask

    task automatic driveLine(input logic v, input int n);
        UART_RX = v;
        repeat (n) @(negedge CLK);
    endtask

    // A low stop bit is followed by idle time so the receiver can resync.
    task automatic sendFrame(input logic [7:0] d, input logic stop);
        driveLine(1'b0, CPB);
        for (int i = 0; i < 8; i++) driveLine(d[i], CPB);
        driveLine(stop, CPB);
        modelFrame(d, stop);
        if (!stop) driveLine(1'b1, 2 * CPB);
    endtask

    task automatic pulseReset();
        INITIALIZE = 1'b1;
        UART_RX    = 1'b1;
        @(negedge CLK);
        INITIALIZE = 1'b0;
        modelReset();
    endtask

    task automatic applyStimulus(input vec_t v);
        setConsumer(v.qs);
        sendFrame(v.data, v.stop);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " queue_t"}, 32'(queue_t), 32'(m_t));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        checkOutput({tag, " frame_error"}, 32'(frame_error), 32'(m_fe));
        if (m_wrote) checkOutput({tag, " data"}, 32'(recv_queue[m_last_addr]), 32'(m_mem[m_last_addr]));
    endtask

    initial begin
        vecs[0] = '{data: 8'h01, stop: 1'b1, qs: 0, exp_t: 2, exp_fe: 1'b0, exp_ovf: 1'b0, addr: 1};
        vecs[1] = '{data: 8'h02, stop: 1'b1, qs: 0, exp_t: 3, exp_fe: 1'b0, exp_ovf: 1'b0, addr: 2};
        vecs[2] = '{data: 8'h03, stop: 1'b1, qs: 0, exp_t: 4, exp_fe: 1'b0, exp_ovf: 1'b0, addr: 3};
        vecs[3] = '{data: 8'h55, stop: 1'b0, qs: 0, exp_t: 4, exp_fe: 1'b1, exp_ovf: 1'b0, addr: 0};
        vecs[4] = '{data: 8'h66, stop: 1'b1, qs: 0, exp_t: 5, exp_fe: 1'b1, exp_ovf: 1'b0, addr: 4};

        INITIALIZE = 1'b1;
        UART_RX    = 1'b1;
        setConsumer(0);
        repeat (3) @(negedge CLK);
        INITIALIZE = 1'b0;
        modelReset();
        driveLine(1'b1, 4);
        checkOutput("reset queue_t", 32'(queue_t), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset frame_error", 32'(frame_error), 32'd0);

        // Single frame with a look at queue_t before and after the stop-bit sample.
        driveLine(1'b0, CPB);
        for (int i = 0; i < 8; i++) driveLine(1'((8'hA5 >> i) & 8'h01), CPB);
        driveLine(1'b1, CPB - 6);
        checkOutput("A5 queue_t before stop sample", 32'(queue_t), 32'd0);
        driveLine(1'b1, 6);
        modelFrame(8'hA5, 1'b1);
        checkOutput("A5 queue_t after", 32'(queue_t), 32'd1);
        checkOutput("A5 data", 32'(recv_queue[0]), 32'h0000_00A5);
        checkOutput("A5 frame_error", 32'(frame_error), 32'd0);
        checkOutput("A5 overflow", 32'(overflow), 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d queue_t", i), 32'(queue_t), 32'(vecs[i].exp_t));
            checkOutput($sformatf("vec%0d frame_error", i), 32'(frame_error), 32'(vecs[i].exp_fe));
            checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            if (vecs[i].stop) checkOutput($sformatf("vec%0d data", i), 32'(recv_queue[vecs[i].addr]), 32'(vecs[i].data));
        end

        driveLine(1'b0, 2);
        driveLine(1'b1, 3 * CPB);
        checkOutput("glitch queue_t", 32'(queue_t), 32'd5);
        sendFrame(8'h5A, 1'b1);
        checkOutput("post-glitch queue_t", 32'(queue_t), 32'd6);
        checkOutput("post-glitch data", 32'(recv_queue[5]), 32'h0000_005A);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: setConsumer(m_s);
                1: setConsumer(m_t);
                2: setConsumer((m_t + 1) % DEPTH);
                default: setConsumer(int'($urandom_range(0, DEPTH - 1)));
            endcase
            sendFrame(8'($urandom), $urandom_range(0, 7) != 0);
            checkModel($sformatf("rand%0d", i));
        end

        pulseReset();
        driveLine(1'b1, 2 * CPB);
        checkOutput("reset keeps contents", 32'(recv_queue[1]), 32'h0000_0001);
        checkOutput("reset2 queue_t", 32'(queue_t), 32'd0);
        checkOutput("reset2 frame_error", 32'(frame_error), 32'd0);

        setConsumer(0);
        for (int i = 0; i < DEPTH; i++) sendFrame(8'(i), 1'b1);
        checkOutput("fill queue_t", 32'(queue_t), 32'd511);
        checkOutput("fill overflow", 32'(overflow), 32'd1);
        checkOutput("fill frame_error", 32'(frame_error), 32'd0);
        checkOutput("fill data[510]", 32'(recv_queue[510]), 32'h0000_00FE);
        checkOutput("fill data[0]", 32'(recv_queue[0]), 32'h0000_0000);
        checkModel("fill model");

        setConsumer(5);
        sendFrame(8'h77, 1'b1);
        checkOutput("wrap data[511]", 32'(recv_queue[511]), 32'h0000_0077);
        checkOutput("wrap queue_t", 32'(queue_t), 32'd0);
        checkOutput("wrap overflow", 32'(overflow), 32'd1);

        sendFrame(8'hC3, 1'b0);
        checkOutput("bad stop frame_error", 32'(frame_error), 32'd1);
        checkOutput("bad stop queue_t", 32'(queue_t), 32'd0);

        // Abort 0x3C halfway through data bit 4.
        driveLine(1'b0, CPB);
        for (int i = 0; i < 4; i++) driveLine(1'((8'h3C >> i) & 8'h01), CPB);
        driveLine(1'b1, CPB / 2);
        pulseReset();
        driveLine(1'b1, 3 * CPB);
        checkOutput("abort queue_t", 32'(queue_t), 32'd0);
        checkOutput("abort overflow", 32'(overflow), 32'd0);
        checkOutput("abort frame_error", 32'(frame_error), 32'd0);
        checkOutput("abort data[0]", 32'(recv_queue[0]), 32'h0000_0000);

        setConsumer(0);
        sendFrame(8'h3C, 1'b1);
        checkOutput("3C data", 32'(recv_queue[0]), 32'h0000_003C);
        checkOutput("3C queue_t", 32'(queue_t), 32'd1);
        checkModel("3C model");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
